// File: rtl/vx_alu_lane_splitter_pkg.sv
// Shared definitions for the partial-lane execute transmit path.
// - calc_num_batch / calc_pid_w derive batch count and batch-index width
//   from the thread and lane counts.
// - batch_hdr_t is the per-batch header {pid, sop, eop} as seen by the
//   commit gather stage (pid sized for the widest supported configuration).
// - lane_opnd_t is the per-lane operand bundle {rs1, rs2, rs3} at the
//   default operand width.
package vx_alu_lane_splitter_pkg;

    localparam int MAX_PID_W = 8;
    localparam int OPND_XLEN = 32;

    function automatic int calc_num_batch(input int thread_cnt, input int num_lanes);
        return thread_cnt / num_lanes;
    endfunction

    function automatic int calc_pid_w(input int num_batch);
        return (num_batch > 1) ? $clog2(num_batch) : 1;
    endfunction

    typedef struct packed {
        logic [MAX_PID_W-1:0] pid;
        logic                 sop;
        logic                 eop;
    } batch_hdr_t;

    typedef struct packed {
        logic [OPND_XLEN-1:0] rs1;
        logic [OPND_XLEN-1:0] rs2;
        logic [OPND_XLEN-1:0] rs3;
    } lane_opnd_t;

endpackage

// File: rtl/vx_alu_lane_splitter_finder.sv
// vx_lane_batch_finder: combinational search over a thread mask split into
// NUM_LANES-wide batches.
// Ports:
//   tmask      in  thread mask to search
//   cur_pid    in  batch currently being emitted
//   from_start in  1: search from batch 0 (new packet); 0: search above cur_pid
//   next_pid   out lowest nonzero batch index matching the search (0 if none)
//   found      out a matching nonzero batch exists
//   is_last    out no nonzero batch exists above next_pid
module vx_lane_batch_finder
    import vx_alu_lane_splitter_pkg::*;
#(
    parameter  int THREAD_CNT = 8,
    parameter  int NUM_LANES  = 2,
    localparam int NUM_BATCH  = calc_num_batch(THREAD_CNT, NUM_LANES),
    localparam int PID_W      = calc_pid_w(NUM_BATCH)
) (
    input  logic [THREAD_CNT-1:0] tmask,
    input  logic [PID_W-1:0]      cur_pid,
    input  logic                  from_start,
    output logic [PID_W-1:0]      next_pid,
    output logic                  found,
    output logic                  is_last
);

    logic [NUM_BATCH-1:0] nz;

    always_comb begin
        nz       = '0;
        next_pid = '0;
        found    = 1'b0;
        is_last  = 1'b1;
        for (int b = 0; b < NUM_BATCH; b++) begin
            nz[b] = |tmask[b*NUM_LANES +: NUM_LANES];
        end
        // Scan downwards so the lowest qualifying batch is the one that sticks.
        for (int b = NUM_BATCH - 1; b >= 0; b--) begin
            if (nz[b] && (from_start || (b > int'(cur_pid)))) begin
                next_pid = b[PID_W-1:0];
                found    = 1'b1;
            end
        end
        for (int b = 0; b < NUM_BATCH; b++) begin
            if (nz[b] && (b > int'(next_pid))) begin
                is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vx_alu_lane_splitter.sv
// vx_alu_lane_splitter: splits one THREAD_CNT-wide dispatch packet into a
// sequence of NUM_LANES-wide batches, skipping batches whose mask slice is
// all zero. A packet with an empty mask still emits one batch (pid 0).
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   in_valid/in_ready          packet handshake
//   in_tmask/in_data/in_meta   packet mask, rs1/rs2/rs3 per thread, metadata
//   out_valid/out_ready        batch handshake
//   out_tmask/out_data         mask and operands of the lanes in batch out_pid
//   out_meta                   packet metadata, repeated on every batch
//   out_pid/out_sop/out_eop    batch index, first/last emitted batch flags
module vx_alu_lane_splitter
    import vx_alu_lane_splitter_pkg::*;
#(
    parameter  int THREAD_CNT = 8,
    parameter  int NUM_LANES  = 2,
    parameter  int XLEN       = 32,
    parameter  int META_W     = 64,
    localparam int NUM_BATCH  = calc_num_batch(THREAD_CNT, NUM_LANES),
    localparam int PID_W      = calc_pid_w(NUM_BATCH),
    localparam int LANE_W     = 3 * XLEN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [THREAD_CNT-1:0]         in_tmask,
    input  logic [THREAD_CNT*LANE_W-1:0]  in_data,
    input  logic [META_W-1:0]             in_meta,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES-1:0]          out_tmask,
    output logic [NUM_LANES*LANE_W-1:0]   out_data,
    output logic [META_W-1:0]             out_meta,
    output logic [PID_W-1:0]              out_pid,
    output logic                          out_sop,
    output logic                          out_eop
);

    // Control state
    logic             held_valid_q, held_valid_d;
    logic [PID_W-1:0] pid_q, pid_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;

    // Held packet, viewed as one entry per batch so the pid selects a slice
    logic [NUM_BATCH-1:0][NUM_LANES-1:0]        tmask_q, tmask_d;
    logic [NUM_BATCH-1:0][NUM_LANES*LANE_W-1:0] data_q, data_d;
    logic [META_W-1:0]                          meta_q, meta_d;

    logic                  accept;
    logic                  fire;
    logic [THREAD_CNT-1:0] f_tmask;
    logic [PID_W-1:0]      f_next;
    logic                  f_found;
    logic                  f_last;

    // eop is registered so in_ready never depends on the finder, which in
    // turn is steered by in_ready (avoids a combinational loop).
    assign in_ready = ~held_valid_q | (held_valid_q & out_ready & eop_q);
    assign accept   = in_valid & in_ready;
    assign fire     = held_valid_q & out_ready;

    // When a new packet may be taken the finder looks at the incoming mask
    // from batch 0; otherwise it looks for the next batch of the held mask.
    assign f_tmask = in_ready ? in_tmask : tmask_q;

    vx_lane_batch_finder #(
        .THREAD_CNT (THREAD_CNT),
        .NUM_LANES  (NUM_LANES)
    ) u_finder (
        .tmask      (f_tmask),
        .cur_pid    (pid_q),
        .from_start (in_ready),
        .next_pid   (f_next),
        .found      (f_found),
        .is_last    (f_last)
    );

    always_comb begin
        held_valid_d = held_valid_q;
        pid_d        = pid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        tmask_d      = tmask_q;
        data_d       = data_q;
        meta_d       = meta_q;
        if (accept) begin
            held_valid_d = 1'b1;
            pid_d        = f_next;
            sop_d        = 1'b1;
            eop_d        = f_last;
            tmask_d      = in_tmask;
            data_d       = in_data;
            meta_d       = in_meta;
        end else if (fire) begin
            if (eop_q) begin
                held_valid_d = 1'b0;
                sop_d        = 1'b1;
            end else begin
                pid_d = f_found ? f_next : pid_q;
                sop_d = 1'b0;
                eop_d = f_last;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_valid_q <= 1'b0;
            pid_q        <= '0;
            sop_q        <= 1'b1;
            eop_q        <= 1'b0;
        end else begin
            held_valid_q <= held_valid_d;
            pid_q        <= pid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
        end
    end

    always_ff @(posedge clk) begin
        tmask_q <= tmask_d;
        data_q  <= data_d;
        meta_q  <= meta_d;
    end

    // Outputs are forced to zero while idle so stale packet contents never
    // show up after a drain or a reset.
    assign out_valid = held_valid_q;
    assign out_pid   = held_valid_q ? pid_q          : '0;
    assign out_sop   = held_valid_q & sop_q;
    assign out_eop   = held_valid_q & eop_q;
    assign out_tmask = held_valid_q ? tmask_q[pid_q] : '0;
    assign out_data  = held_valid_q ? data_q[pid_q]  : '0;
    assign out_meta  = held_valid_q ? meta_q         : '0;

endmodule

// File: tb/tb_vx_alu_lane_splitter.sv
module tb_vx_alu_lane_splitter;

    localparam int TC = 8;
    localparam int NL = 2;
    localparam int XL = 32;
    localparam int MW = 64;
    localparam int NB = TC / NL;
    localparam int PW = 2;
    localparam int LW = NL * 3 * XL;
    localparam int DW = TC * 3 * XL;
    localparam int BW = PW + NL + 2 + MW + LW;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [TC-1:0]  in_tmask;
    logic [DW-1:0]  in_data;
    logic [MW-1:0]  in_meta;
    logic           out_valid;
    logic           out_ready;
    logic [NL-1:0]  out_tmask;
    logic [LW-1:0]  out_data;
    logic [MW-1:0]  out_meta;
    logic [PW-1:0]  out_pid;
    logic           out_sop;
    logic           out_eop;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    vx_alu_lane_splitter #(
        .THREAD_CNT (TC),
        .NUM_LANES  (NL),
        .XLEN       (XL),
        .META_W     (MW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tmask  (in_tmask),
        .in_data   (in_data),
        .in_meta   (in_meta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tmask (out_tmask),
        .out_data  (out_data),
        .out_meta  (out_meta),
        .out_pid   (out_pid),
        .out_sop   (out_sop),
        .out_eop   (out_eop)
    );

    typedef struct {
        logic [TC-1:0]        tmask;
        int                   n;
        logic [3:0][PW-1:0]   pids;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Expected batch for batch index p: lanes are threads p*NL .. p*NL+NL-1.
    function automatic logic [BW-1:0] exp_batch(input logic [DW-1:0] d, input logic [MW-1:0] m,
                                                input logic [TC-1:0] t, input int p,
                                                input logic s, input logic e);
        logic [PW-1:0] pp;
        pp = p[PW-1:0];
        return {pp, t[p*NL +: NL], s, e, m, d[p*LW +: LW]};
    endfunction

    function automatic logic [BW-1:0] got_batch();
        return {out_pid, out_tmask, out_sop, out_eop, out_meta, out_data};
    endfunction

    task automatic push_packet(input logic [TC-1:0] t, input logic [DW-1:0] d, input logic [MW-1:0] m);
        int idx[$];
        for (int b = 0; b < NB; b++) if (t[b*NL +: NL] != '0) idx.push_back(b);
        if (idx.size() == 0) idx.push_back(0);
        for (int k = 0; k < idx.size(); k++)
            exp_q.push_back(exp_batch(d, m, t, idx[k], k == 0, k == idx.size() - 1));
    endtask

    task automatic rand_payload();
        for (int i = 0; i < TC * 3; i++) in_data[i*XL +: XL] = $urandom();
        in_meta = {$urandom(), $urandom()};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic [TC-1:0] t, input int n, input int p0, input int p1,
                                 input int p2, input int p3);
        vec_t v;
        v.tmask   = t;
        v.n       = n;
        v.pids[0] = p0[PW-1:0];
        v.pids[1] = p1[PW-1:0];
        v.pids[2] = p2[PW-1:0];
        v.pids[3] = p3[PW-1:0];
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d1, d2;
        logic [MW-1:0] m1, m2;
        logic [TC-1:0] t;
        logic          exp_ir;

        vt[0] = mkv(8'hFF, 4, 0, 1, 2, 3);
        vt[1] = mkv(8'h30, 1, 2, 0, 0, 0);
        vt[2] = mkv(8'h81, 2, 0, 3, 0, 0);
        vt[3] = mkv(8'h00, 1, 0, 0, 0, 0);
        vt[4] = mkv(8'h0C, 1, 1, 0, 0, 0);
        vt[5] = mkv(8'h42, 2, 0, 3, 0, 0);

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_tmask  = '0;
        in_data   = '0;
        in_meta   = '0;
        out_ready = 1'b0;
        rand_payload();
        in_tmask  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_in_ready",  512'(in_ready),  512'(1));
        chk("rst_pid",       512'(out_pid),   512'(0));
        chk("rst_sop",       512'(out_sop),   512'(0));
        chk("rst_eop",       512'(out_eop),   512'(0));
        chk("rst_tmask",     512'(out_tmask), 512'(0));
        chk("rst_data",      512'(out_data),  512'(0));
        chk("rst_meta",      512'(out_meta),  512'(0));
        reset = 1'b1;
        step();

        // Table-driven single packets, out_ready held high
        for (int v = 0; v < 6; v++) begin
            in_valid  = 1'b1;
            in_tmask  = vt[v].tmask;
            out_ready = 1'b1;
            rand_payload();
            d1 = in_data;
            m1 = in_meta;
            #1;
            chk($sformatf("tv%0d_idle_rdy", v), 512'(in_ready), 512'(1));
            chk($sformatf("tv%0d_idle_vld", v), 512'(out_valid), 512'(0));
            step();
            in_valid = 1'b0;
            rand_payload();
            for (int k = 0; k < vt[v].n; k++) begin
                #1;
                chk($sformatf("tv%0d_b%0d_vld", v, k), 512'(out_valid), 512'(1));
                chk($sformatf("tv%0d_b%0d_batch", v, k), 512'(got_batch()),
                    512'(exp_batch(d1, m1, vt[v].tmask, int'(vt[v].pids[k]), k == 0, k == vt[v].n - 1)));
                chk($sformatf("tv%0d_b%0d_rdy", v, k), 512'(in_ready), 512'(k == vt[v].n - 1));
                step();
            end
            #1;
            chk($sformatf("tv%0d_done_vld", v), 512'(out_valid), 512'(0));
        end

        // Backpressure at pid1, then back-to-back second packet
        in_valid = 1'b1;
        in_tmask = 8'hFF;
        rand_payload();
        d1 = in_data;
        m1 = in_meta;
        step();
        in_valid = 1'b0;
        #1;
        chk("bp_pid0", 512'(got_batch()), 512'(exp_batch(d1, m1, 8'hFF, 0, 1'b1, 1'b0)));
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_stall%0d", i), 512'(got_batch()), 512'(exp_batch(d1, m1, 8'hFF, 1, 1'b0, 1'b0)));
            chk($sformatf("bp_stall%0d_vld", i), 512'(out_valid), 512'(1));
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_pid1", 512'(got_batch()), 512'(exp_batch(d1, m1, 8'hFF, 1, 1'b0, 1'b0)));
        step();
        #1;
        chk("bp_pid2", 512'(got_batch()), 512'(exp_batch(d1, m1, 8'hFF, 2, 1'b0, 1'b0)));
        step();
        in_valid = 1'b1;
        in_tmask = 8'h81;
        rand_payload();
        d2 = in_data;
        m2 = in_meta;
        #1;
        chk("bp_pid3", 512'(got_batch()), 512'(exp_batch(d1, m1, 8'hFF, 3, 1'b0, 1'b1)));
        chk("bp_pid3_rdy", 512'(in_ready), 512'(1));
        step();
        in_valid = 1'b0;
        #1;
        chk("b2b_vld", 512'(out_valid), 512'(1));
        chk("b2b_pid0", 512'(got_batch()), 512'(exp_batch(d2, m2, 8'h81, 0, 1'b1, 1'b0)));
        step();
        #1;
        chk("b2b_pid3", 512'(got_batch()), 512'(exp_batch(d2, m2, 8'h81, 3, 1'b0, 1'b1)));
        step();
        #1;
        chk("b2b_done", 512'(out_valid), 512'(0));

        // Reset in the middle of a packet
        in_valid = 1'b1;
        in_tmask = 8'hFF;
        rand_payload();
        d1 = in_data;
        m1 = in_meta;
        step();
        in_valid = 1'b0;
        #1;
        chk("mr_pid0", 512'(got_batch()), 512'(exp_batch(d1, m1, 8'hFF, 0, 1'b1, 1'b0)));
        step();
        #1;
        chk("mr_pid1", 512'(got_batch()), 512'(exp_batch(d1, m1, 8'hFF, 1, 1'b0, 1'b0)));
        step();
        reset = 1'b0;
        #1;
        chk("mr_async_vld", 512'(out_valid), 512'(0));
        chk("mr_async_rdy", 512'(in_ready), 512'(1));
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mr_after%0d_vld", i), 512'(out_valid), 512'(0));
            chk($sformatf("mr_after%0d_rdy", i), 512'(in_ready), 512'(1));
            step();
        end

        // Randomized traffic against the queue model
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom() % 4) != 0;
            out_ready = ($urandom() % 3) != 0;
            case ($urandom() % 6)
                0:       t = 8'h00;
                1:       t = 8'(1 << ($urandom() % TC));
                2:       t = 8'hFF;
                default: t = 8'($urandom());
            endcase
            in_tmask = t;
            rand_payload();
            #1;
            exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            chk($sformatf("rnd%0d_vld", cyc), 512'(out_valid), 512'(exp_q.size() != 0));
            chk($sformatf("rnd%0d_rdy", cyc), 512'(in_ready), 512'(exp_ir));
            if (exp_q.size() != 0)
                chk($sformatf("rnd%0d_batch", cyc), 512'(got_batch()), 512'(exp_q[0]));
            if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && exp_ir) push_packet(in_tmask, in_data, in_meta);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            #1;
            chk($sformatf("drain%0d_batch", i), 512'(got_batch()), 512'(exp_q[0]));
            void'(exp_q.pop_front());
            step();
        end
        #1;
        chk("drain_left", 512'(exp_q.size()), 512'(0));
        chk("drain_vld", 512'(out_valid), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
